alu_arbiter: RTL and testbench



---
 rtl/alu_arbiter_if.sv | 26 ++
 rtl/alu_arbiter.sv | 122 ++++++++++++
 tb/tb_alu_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Requester-side handshake bundle for the shared ALU arbiter.
// One instance per requester: operation request plus held response.
interface alu_req_if #(
    parameter int WIDTH = 64,
    parameter int CTRLW = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [CTRLW-1:0] ctrl;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_w;
    logic             rsp_zero;

    modport master (
        output req_valid, a, b, ctrl, rsp_ready,
        input  req_ready, rsp_valid, rsp_w, rsp_zero
    );

    modport slave (
        input  req_valid, a, b, ctrl, rsp_ready,
        output req_ready, rsp_valid, rsp_w, rsp_zero
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Operands are registered onto the ALU; results land in per-requester slots.
module alu_arbiter #(
    parameter int WIDTH = 64,
    parameter int CTRLW = 4
) (
    input  logic             CLK,
    input  logic             Reset,
    alu_req_if.slave         req0,
    alu_req_if.slave         req1,
    output logic [WIDTH-1:0] AluBusA,
    output logic [WIDTH-1:0] AluBusB,
    output logic [CTRLW-1:0] AluCtrl,
    input  logic [WIDTH-1:0] AluBusW,
    input  logic             AluZero,
    output logic             Busy
);

    typedef enum logic {IDLE, EXEC} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             last;
    logic             owner;
    logic [1:0]       elig;
    logic [1:0]       grant;
    logic [1:0]       rsp_valid;
    logic [WIDTH-1:0] rsp_w0;
    logic [WIDTH-1:0] rsp_w1;
    logic             rsp_zero0;
    logic             rsp_zero1;

    // A full response slot blocks its requester unless it is popped this cycle
    assign elig[0] = req0.req_valid && (!rsp_valid[0] || req0.rsp_ready);
    assign elig[1] = req1.req_valid && (!rsp_valid[1] || req1.rsp_ready);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = 2'b00;
        unique case (state)
            IDLE: begin
                unique case (elig)
                    2'b01:   grant = 2'b01;
                    2'b10:   grant = 2'b10;
                    2'b11:   grant = last ? 2'b01 : 2'b10;
                    default: grant = 2'b00;
                endcase
                if (grant != 2'b00) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            AluBusA   <= '0;
            AluBusB   <= '0;
            AluCtrl   <= '0;
            last      <= 1'b1;
            owner     <= 1'b0;
            rsp_valid <= 2'b00;
            rsp_w0    <= '0;
            rsp_w1    <= '0;
            rsp_zero0 <= 1'b0;
            rsp_zero1 <= 1'b0;
        end else begin
            if (grant[0]) begin
                AluBusA <= req0.a;
                AluBusB <= req0.b;
                AluCtrl <= req0.ctrl;
                owner   <= 1'b0;
                last    <= 1'b0;
            end else if (grant[1]) begin
                AluBusA <= req1.a;
                AluBusB <= req1.b;
                AluCtrl <= req1.ctrl;
                owner   <= 1'b1;
                last    <= 1'b1;
            end
            if (rsp_valid[0] && req0.rsp_ready) begin
                rsp_valid[0] <= 1'b0;
            end
            if (rsp_valid[1] && req1.rsp_ready) begin
                rsp_valid[1] <= 1'b0;
            end
            // The owner's slot is always empty here, so no pop can collide
            if (state == EXEC) begin
                if (owner) begin
                    rsp_valid[1] <= 1'b1;
                    rsp_w1       <= AluBusW;
                    rsp_zero1    <= AluZero;
                end else begin
                    rsp_valid[0] <= 1'b1;
                    rsp_w0       <= AluBusW;
                    rsp_zero0    <= AluZero;
                end
            end
        end
    end

    assign req0.req_ready = grant[0];
    assign req1.req_ready = grant[1];
    assign req0.rsp_valid = rsp_valid[0];
    assign req1.rsp_valid = rsp_valid[1];
    assign req0.rsp_w     = rsp_w0;
    assign req1.rsp_w     = rsp_w1;
    assign req0.rsp_zero  = rsp_zero0;
    assign req1.rsp_zero  = rsp_zero1;
    assign Busy           = (state == EXEC);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: vector table, directed corner sequences,
// and a randomized run against a rule-level reference model.
module tb_alu_arbiter;

    localparam int W = 64;
    localparam int C = 4;
    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_LSL   = 4'd3;
    localparam logic [3:0] OP_LSR   = 4'd4;
    localparam logic [3:0] OP_SUB   = 4'd6;
    localparam logic [3:0] OP_PASSB = 4'd7;

    logic         CLK = 1'b0;
    logic         Reset;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_w;
    logic [C-1:0] alu_ctrl;
    logic         alu_zero;
    logic         busy;

    always #5 CLK = ~CLK;

    alu_req_if #(.WIDTH(W), .CTRLW(C)) r0 ();
    alu_req_if #(.WIDTH(W), .CTRLW(C)) r1 ();

    function automatic logic [63:0] alu_f(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input logic [3:0] c);
        case (c)
            OP_AND:   return a & b;
            OP_OR:    return a | b;
            OP_ADD:   return a + b;
            OP_LSL:   return a << b[5:0];
            OP_LSR:   return a >> b[5:0];
            OP_SUB:   return a - b;
            OP_PASSB: return b;
            default:  return 64'd0;
        endcase
    endfunction

    // External combinational ALU
    assign alu_w    = alu_f(alu_a, alu_b, alu_ctrl);
    assign alu_zero = (alu_w == 64'd0);

    alu_arbiter #(.WIDTH(W), .CTRLW(C)) dut (
        .CLK     (CLK),
        .Reset   (Reset),
        .req0    (r0),
        .req1    (r1),
        .AluBusA (alu_a),
        .AluBusB (alu_b),
        .AluCtrl (alu_ctrl),
        .AluBusW (alu_w),
        .AluZero (alu_zero),
        .Busy    (busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc;
        @(posedge CLK);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic idle_inputs;
        r0.req_valid = 1'b0;
        r1.req_valid = 1'b0;
        r0.rsp_ready = 1'b1;
        r1.rsp_ready = 1'b1;
        r0.a = '0; r0.b = '0; r0.ctrl = '0;
        r1.a = '0; r1.b = '0; r1.ctrl = '0;
    endtask

    typedef struct {
        logic [3:0]  ctrl;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] w;
        logic        z;
    } vec_t;

    vec_t vecs[7];

    task automatic run_single(input vec_t v);
        r0.req_valid = 1'b1;
        r0.a = v.a; r0.b = v.b; r0.ctrl = v.ctrl;
        settle;
        chk("single_ready0", r0.req_ready, 1);
        chk("single_ready1", r1.req_ready, 0);
        cyc;
        r0.req_valid = 1'b0;
        r0.a = '0; r0.b = '0;
        settle;
        chk("single_busy", busy, 1);
        chk("single_aluctrl", alu_ctrl, v.ctrl);
        chk("single_ready_exec", r0.req_ready, 0);
        chk("single_rsp_early", r0.rsp_valid, 0);
        cyc;
        settle;
        chk("single_rsp_valid", r0.rsp_valid, 1);
        chk("single_rsp_w", r0.rsp_w, v.w);
        chk("single_rsp_zero", r0.rsp_zero, v.z);
        chk("single_idle", busy, 0);
        cyc;
        settle;
        chk("single_popped", r0.rsp_valid, 0);
    endtask

    // Reference model state (rule level)
    logic        m_busy;
    logic        m_last;
    int          m_own;
    logic [63:0] m_pend;
    logic        m_v[2];
    logic [63:0] m_w[2];
    logic        m_z[2];

    initial begin
        logic [3:0]  ops[8];
        logic [63:0] w_hold;
        int          ngr;
        int          cnt0;
        int          prev;
        logic        seen;

        vecs[0] = '{OP_ADD,   64'h1234, 64'hABCD0000, 64'hABCD1234, 1'b0};
        vecs[1] = '{OP_AND,   64'h8c5401b5505d55b0, 64'hd, 64'h0, 1'b1};
        vecs[2] = '{OP_SUB,   64'hF, 64'h3, 64'hC, 1'b0};
        vecs[3] = '{OP_LSR,   64'h404e328b85888a92, 64'hc,
                    64'h404e328b85888, 1'b0};
        vecs[4] = '{OP_SUB,   64'd5, 64'd5, 64'd0, 1'b1};
        vecs[5] = '{OP_PASSB, 64'hdead, {64{1'b1}}, {64{1'b1}}, 1'b0};
        vecs[6] = '{OP_OR,    64'h0, 64'h0, 64'h0, 1'b1};
        ops = '{OP_AND, OP_OR, OP_ADD, OP_LSL, OP_LSR, OP_SUB, OP_PASSB, 4'd5};

        // Reset state and contention from reset
        Reset = 1'b1;
        idle_inputs;
        r0.a = 64'h8c5401b5505d55b0; r0.b = 64'hd; r0.ctrl = OP_AND;
        r1.a = 64'hF; r1.b = 64'h3; r1.ctrl = OP_SUB;
        r0.req_valid = 1'b1;
        r1.req_valid = 1'b1;
        cyc;
        cyc;
        Reset = 1'b0;
        settle;
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_ctrl", alu_ctrl, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp0_valid", r0.rsp_valid, 0);
        chk("rst_rsp1_valid", r1.rsp_valid, 0);
        chk("rst_rsp0_w", r0.rsp_w, 0);
        chk("rst_rsp1_w", r1.rsp_w, 0);
        chk("cont_ready0", r0.req_ready, 1);
        chk("cont_ready1", r1.req_ready, 0);
        cyc;
        r0.req_valid = 1'b0;
        settle;
        chk("cont_exec_ready1", r1.req_ready, 0);
        chk("cont_exec_busy", busy, 1);
        cyc;
        settle;
        chk("cont_rsp0_valid", r0.rsp_valid, 1);
        chk("cont_rsp0_w", r0.rsp_w, 0);
        chk("cont_rsp0_zero", r0.rsp_zero, 1);
        chk("cont_ready1_late", r1.req_ready, 1);
        cyc;
        r1.req_valid = 1'b0;
        settle;
        cyc;
        settle;
        chk("cont_rsp1_valid", r1.rsp_valid, 1);
        chk("cont_rsp1_w", r1.rsp_w, 64'hC);
        chk("cont_rsp1_zero", r1.rsp_zero, 0);
        r0.req_valid = 1'b1;
        r1.req_valid = 1'b1;
        settle;
        chk("cont_tie_ready0", r0.req_ready, 1);
        chk("cont_tie_ready1", r1.req_ready, 0);
        cyc;
        idle_inputs;
        cyc;
        cyc;
        cyc;

        // Vector table, requester 0 alone
        foreach (vecs[i]) run_single(vecs[i]);

        // Backpressure: full slot blocks the requester
        r0.rsp_ready = 1'b0;
        r0.req_valid = 1'b1;
        r0.a = 64'd1; r0.b = 64'd1; r0.ctrl = OP_ADD;
        settle;
        cyc;
        r0.a = 64'h404e328b85888a92; r0.b = 64'hc; r0.ctrl = OP_LSR;
        settle;
        chk("bp_exec_ready0", r0.req_ready, 0);
        cyc;
        settle;
        for (int k = 0; k < 3; k++) begin
            chk("bp_ready0_blocked", r0.req_ready, 0);
            chk("bp_rsp0_valid", r0.rsp_valid, 1);
            chk("bp_rsp0_w_stable", r0.rsp_w, 64'd2);
            cyc;
            settle;
        end
        r0.rsp_ready = 1'b1;
        settle;
        chk("bp_pop_accept_ready", r0.req_ready, 1);
        cyc;
        r0.req_valid = 1'b0;
        settle;
        chk("bp_popped", r0.rsp_valid, 0);
        chk("bp_busy", busy, 1);
        cyc;
        settle;
        chk("bp_next_valid", r0.rsp_valid, 1);
        chk("bp_next_w", r0.rsp_w, 64'h404e328b85888);
        cyc;
        settle;

        // Fairness: both streaming; Last is now 0, so grants run 1,0,1,...
        r0.req_valid = 1'b1;
        r1.req_valid = 1'b1;
        ngr = 0;
        cnt0 = 0;
        prev = 0;
        for (int k = 0; k < 60 && ngr < 12; k++) begin
            r0.a = {$urandom, $urandom}; r0.b = {$urandom, $urandom};
            r1.a = {$urandom, $urandom}; r1.b = {$urandom, $urandom};
            r0.ctrl = ops[$urandom_range(0, 7)];
            r1.ctrl = ops[$urandom_range(0, 7)];
            settle;
            chk("fair_busy_toggle", busy, k[0]);
            chk("fair_one_ready", r0.req_ready & r1.req_ready, 0);
            if (r0.req_ready || r1.req_ready) begin
                prev = r1.req_ready ? 1 : 0;
                chk("fair_alternate", prev, (ngr + 1) % 2);
                if (prev == 0) cnt0++;
                ngr++;
            end
            cyc;
        end
        chk("fair_grants", ngr, 12);
        chk("fair_grants_req0", cnt0, 6);
        idle_inputs;
        cyc;
        cyc;
        cyc;
        settle;

        // Reset while an operation is in EXEC
        r0.req_valid = 1'b1;
        r0.a = 64'h55; r0.b = 64'h1; r0.ctrl = OP_PASSB;
        settle;
        cyc;
        r0.req_valid = 1'b0;
        settle;
        chk("rexec_busy", busy, 1);
        chk("rexec_alu_b", alu_b, 1);
        Reset = 1'b1;
        cyc;
        Reset = 1'b0;
        settle;
        chk("rexec_alu_a", alu_a, 0);
        chk("rexec_alu_b0", alu_b, 0);
        chk("rexec_alu_ctrl", alu_ctrl, 0);
        chk("rexec_busy0", busy, 0);
        chk("rexec_rsp0_w", r0.rsp_w, 0);
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            seen |= r0.rsp_valid;
            cyc;
            settle;
        end
        chk("rexec_no_rsp", seen, 0);
        run_single(vecs[0]);

        // Pop timing on requester 1
        r1.rsp_ready = 1'b0;
        r1.req_valid = 1'b1;
        r1.a = 64'd7; r1.b = 64'd8; r1.ctrl = OP_ADD;
        settle;
        chk("pop_ready1", r1.req_ready, 1);
        cyc;
        r1.req_valid = 1'b0;
        cyc;
        settle;
        chk("pop_rsp1_valid", r1.rsp_valid, 1);
        chk("pop_rsp1_w", r1.rsp_w, 64'd15);
        r1.rsp_ready = 1'b1;
        cyc;
        r1.rsp_ready = 1'b0;
        settle;
        chk("pop_rsp1_dropped", r1.rsp_valid, 0);
        chk("pop_rsp1_w_kept", r1.rsp_w, 64'd15);
        cyc;
        settle;
        chk("pop_rsp1_stays", r1.rsp_valid, 0);
        w_hold = r1.rsp_w;
        chk("pop_rsp1_w_hold", w_hold, 64'd15);
        idle_inputs;

        // Randomized run against the reference model
        Reset = 1'b1;
        cyc;
        Reset = 1'b0;
        m_busy = 1'b0;
        m_last = 1'b1;
        m_own  = 0;
        m_pend = '0;
        m_v = '{1'b0, 1'b0};
        m_w = '{64'd0, 64'd0};
        m_z = '{1'b0, 1'b0};
        for (int k = 0; k < 600; k++) begin
            int   g;
            logic el0;
            logic el1;
            r0.req_valid = ($urandom_range(0, 3) != 0);
            r1.req_valid = ($urandom_range(0, 3) != 0);
            r0.rsp_ready = ($urandom_range(0, 2) != 0);
            r1.rsp_ready = ($urandom_range(0, 2) != 0);
            r0.a = {$urandom, $urandom};
            r0.b = ($urandom_range(0, 1) != 0) ? {$urandom, $urandom}
                                               : 64'($urandom_range(0, 70));
            r1.a = {$urandom, $urandom};
            r1.b = ($urandom_range(0, 1) != 0) ? r1.a
                                               : 64'($urandom_range(0, 70));
            r0.ctrl = ops[$urandom_range(0, 7)];
            r1.ctrl = ops[$urandom_range(0, 7)];
            settle;
            el0 = r0.req_valid && (!m_v[0] || r0.rsp_ready);
            el1 = r1.req_valid && (!m_v[1] || r1.rsp_ready);
            g = -1;
            if (!m_busy) begin
                if (el0 && el1) g = m_last ? 0 : 1;
                else if (el0)   g = 0;
                else if (el1)   g = 1;
            end
            chk("rnd_ready0", r0.req_ready, g == 0);
            chk("rnd_ready1", r1.req_ready, g == 1);
            chk("rnd_busy", busy, m_busy);
            chk("rnd_rsp0_valid", r0.rsp_valid, m_v[0]);
            chk("rnd_rsp1_valid", r1.rsp_valid, m_v[1]);
            if (m_v[0]) begin
                chk("rnd_rsp0_w", r0.rsp_w, m_w[0]);
                chk("rnd_rsp0_zero", r0.rsp_zero, m_z[0]);
            end
            if (m_v[1]) begin
                chk("rnd_rsp1_w", r1.rsp_w, m_w[1]);
                chk("rnd_rsp1_zero", r1.rsp_zero, m_z[1]);
            end
            if (m_v[0] && r0.rsp_ready) m_v[0] = 1'b0;
            if (m_v[1] && r1.rsp_ready) m_v[1] = 1'b0;
            if (m_busy) begin
                m_v[m_own] = 1'b1;
                m_w[m_own] = m_pend;
                m_z[m_own] = (m_pend == 64'd0);
                m_busy = 1'b0;
            end else if (g >= 0) begin
                m_pend = (g == 0) ? alu_f(r0.a, r0.b, r0.ctrl)
                                  : alu_f(r1.a, r1.b, r1.ctrl);
                m_own  = g;
                m_last = (g == 1);
                m_busy = 1'b1;
            end
            cyc;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
